// File: rtl/mem_stage_waitstate.sv
// mem_stage_waitstate
//   MEM stage of the 5-stage pipeline. It resolves branches (pcsrc) and accesses
//   the on-chip data RAM with WAIT_STATES extra cycles per load or store. It also
//   holds the MEM/WB pipeline register. While an access is in flight, stall holds
//   the upstream stages and a bubble is loaded into WB.
//
//   Optional feature macro: MEM_STAGE_SUBWORD_EN
//     defined   : byte/half stores write only their lanes (little-endian),
//                 sub-word loads sign-extend or zero-extend (unsigned_ld).
//     undefined : size/unsigned_ld ignored, every access is a full word.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     valid_in              EX/MEM latch holds a real instruction
//     wb_ctrl_in[1:0]       write-back control, passed through
//     branch, zero          branch control and ALU zero flag -> pcsrc
//     mem_read, mem_write   memory control (both set = write)
//     alu_result            byte address / ALU result
//     write_data            store data
//     write_reg             destination register index
//     size, unsigned_ld     access size (00 byte, 01 half, 1x word), zero-extend
//     pcsrc, stall          combinational outputs
//     mem_wb_ctrl, read_data, mem_alu_result, mem_write_reg,
//     valid_out, misaligned registered MEM/WB outputs
//
//   state  | meaning
//   S_IDLE | no access in flight; zero-wait accesses commit here
//   S_WAIT | counting down wait states; commits when cnt reaches 0

module mem_stage_waitstate #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int REG_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [1:0]        wb_ctrl_in,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic              pcsrc,
  output logic              stall,
  output logic [1:0]        mem_wb_ctrl,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic              valid_out,
  output logic              misaligned
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic       HAS_WAIT = (WAIT_STATES > 0);
  // Unused when WAIT_STATES is 0.
  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [1:0]        mem_wb_ctrl_q, mem_wb_ctrl_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] mem_alu_result_q, mem_alu_result_d;
  logic [REG_W-1:0]  mem_write_reg_q, mem_write_reg_d;
  logic              valid_out_q, valid_out_d;
  logic              misaligned_q, misaligned_d;

  logic [DATA_W-1:0] ram [DEPTH];

  logic              mem_instr;
  logic              is_load;
  logic              commit;
  logic              ram_we;
  logic [1:0]        addr_lo;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] ram_word;
  logic              misalign;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] ld_val;

  assign pcsrc     = valid_in & branch & zero;
  assign mem_instr = valid_in & (mem_read | mem_write);
  assign is_load   = mem_read & ~mem_write;
  assign addr_lo   = alu_result[1:0];
  assign idx       = alu_result[AW+1:2];
  assign ram_word  = ram[idx];

`ifdef MEM_STAGE_SUBWORD_EN
  logic [4:0]        lane_sh;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] ld_shifted;

  assign lane_sh    = {addr_lo, 3'b000};
  assign ld_shifted = ram_word >> lane_sh;

  always_comb begin
    misalign  = 1'b0;
    lane_mask = '1;
    ld_val    = ram_word;
    case (size)
      2'b00: begin
        lane_mask = DATA_W'(8'hFF) << lane_sh;
        ld_val    = {{(DATA_W-8){~unsigned_ld & ld_shifted[7]}}, ld_shifted[7:0]};
      end
      2'b01: begin
        misalign  = addr_lo[0];
        lane_mask = DATA_W'(16'hFFFF) << lane_sh;
        ld_val    = {{(DATA_W-16){~unsigned_ld & ld_shifted[15]}}, ld_shifted[15:0]};
      end
      default: misalign = |addr_lo;
    endcase
  end

  // Read-modify-write of the addressed word keeps untouched lanes intact.
  assign wr_word = (ram_word & ~lane_mask) | ((write_data << lane_sh) & lane_mask);
`else
  logic unused_cfg;
  assign unused_cfg = ^{size, unsigned_ld};
  assign misalign   = |addr_lo;
  assign wr_word    = write_data;
  assign ld_val     = ram_word;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_instr && HAS_WAIT) begin
          stall   = 1'b1;
          cnt_d   = WS_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = 4'(cnt_q - 4'd1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset gates the write so an aborted access can never land in the RAM.
  assign commit = valid_in & ~stall;
  assign ram_we = commit & mem_write & ~misalign & ~reset;

  always_comb begin
    valid_out_d      = 1'b0;
    mem_wb_ctrl_d    = 2'b00;
    read_data_d      = read_data_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_write_reg_d  = mem_write_reg_q;
    misaligned_d     = misaligned_q;
    if (commit) begin
      valid_out_d      = 1'b1;
      mem_wb_ctrl_d    = wb_ctrl_in;
      mem_alu_result_d = alu_result;
      mem_write_reg_d  = write_reg;
      misaligned_d     = (mem_read | mem_write) & misalign;
      read_data_d      = (is_load & ~misalign) ? ld_val : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      valid_out_q      <= 1'b0;
      mem_wb_ctrl_q    <= 2'b00;
      read_data_q      <= '0;
      mem_alu_result_q <= '0;
      mem_write_reg_q  <= '0;
      misaligned_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      valid_out_q      <= valid_out_d;
      mem_wb_ctrl_q    <= mem_wb_ctrl_d;
      read_data_q      <= read_data_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_write_reg_q  <= mem_write_reg_d;
      misaligned_q     <= misaligned_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= wr_word;
    end
  end

  assign valid_out      = valid_out_q;
  assign mem_wb_ctrl    = mem_wb_ctrl_q;
  assign read_data      = read_data_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_write_reg  = mem_write_reg_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_stage_waitstate.sv
// Testbench for mem_stage_waitstate. Three instances: index 0 with
// WAIT_STATES=0, index 1 with WAIT_STATES=3 and index 2 with WAIT_STATES=4.
// Each instance has its own stimulus; reset is shared.

module tb_mem_stage_waitstate;

  logic clk = 1'b0;
  logic reset;

  logic        vi [3];
  logic        br [3];
  logic        zr [3];
  logic        rd [3];
  logic        wr [3];
  logic        uns [3];
  logic [1:0]  ctrl_in [3];
  logic [1:0]  sz [3];
  logic [31:0] addr [3];
  logic [31:0] wd [3];
  logic [4:0]  wreg [3];

  logic        pcsrc_o [3];
  logic        stall_o [3];
  logic        vo [3];
  logic        mis [3];
  logic [1:0]  ctrl_o [3];
  logic [31:0] rdata [3];
  logic [31:0] alu_o [3];
  logic [4:0]  wreg_o [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_waitstate #(
      .DATA_W(32), .DEPTH(256), .WAIT_STATES(g == 0 ? 0 : g + 2), .REG_W(5)
    ) u_dut (
      .clk(clk), .reset(reset), .valid_in(vi[g]), .wb_ctrl_in(ctrl_in[g]),
      .branch(br[g]), .mem_read(rd[g]), .mem_write(wr[g]), .zero(zr[g]),
      .alu_result(addr[g]), .write_data(wd[g]), .write_reg(wreg[g]),
      .size(sz[g]), .unsigned_ld(uns[g]), .pcsrc(pcsrc_o[g]), .stall(stall_o[g]),
      .mem_wb_ctrl(ctrl_o[g]), .read_data(rdata[g]), .mem_alu_result(alu_o[g]),
      .mem_write_reg(wreg_o[g]), .valid_out(vo[g]), .misaligned(mis[g])
    );
  end

  task automatic set_in(input int d, input logic v, input logic b, input logic z,
                        input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] data, input logic [1:0] s, input logic u,
                        input logic [1:0] c, input logic [4:0] rg);
    vi[d] = v; br[d] = b; zr[d] = z; rd[d] = r; wr[d] = w;
    addr[d] = a; wd[d] = data; sz[d] = s; uns[d] = u; ctrl_in[d] = c; wreg[d] = rg;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({vo[d], ctrl_o[d], rdata[d], alu_o[d], wreg_o[d], mis[d], stall_o[d]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: got vo=%b ctrl=%b rd=%h alu=%h reg=%h mis=%b stall=%b expected all 0",
                 d, vo[d], ctrl_o[d], rdata[d], alu_o[d], wreg_o[d], mis[d], stall_o[d]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_in(0, 1, 0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 2'b01, 5'd3);
    checks++;
    if (stall_o[0] !== 1'b0) begin failures++; $display("FAIL basic_store_stall: got %b expected 0", stall_o[0]); end
    step();
    checks++;
    if ({vo[0], ctrl_o[0], rdata[0], mis[0]} !== {1'b1, 2'b01, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL basic_store_out: got vo=%b ctrl=%b rd=%h mis=%b expected vo=1 ctrl=01 rd=0 mis=0",
               vo[0], ctrl_o[0], rdata[0], mis[0]);
    end
    set_in(0, 1, 0, 0, 1, 0, 32'h10, 32'h0, 2'b10, 0, 2'b11, 5'd7);
    checks++;
    if (stall_o[0] !== 1'b0) begin failures++; $display("FAIL basic_load_stall: got %b expected 0", stall_o[0]); end
    step();
    checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_load_data: got %h expected deadbeef", rdata[0]); end
    checks++;
    if ({vo[0], ctrl_o[0], wreg_o[0], alu_o[0]} !== {1'b1, 2'b11, 5'd7, 32'h10}) begin
      failures++;
      $display("FAIL basic_load_ctrl: got vo=%b ctrl=%b reg=%0d alu=%h expected vo=1 ctrl=11 reg=7 alu=10",
               vo[0], ctrl_o[0], wreg_o[0], alu_o[0]);
    end
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 2'b11, 5'd0);
    step();
    checks++;
    if ({vo[0], ctrl_o[0], rdata[0]} !== {1'b0, 2'b00, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL basic_bubble: got vo=%b ctrl=%b rd=%h expected vo=0 ctrl=00 rd=deadbeef",
               vo[0], ctrl_o[0], rdata[0]);
    end
  endtask

  task automatic test_branch();
    set_in(0, 1, 1, 1, 0, 0, 32'h0, 32'h0, 2'b10, 0, 2'b00, 5'd0);
    checks++;
    if ({pcsrc_o[0], stall_o[0]} !== 2'b10) begin
      failures++;
      $display("FAIL branch_taken: got pcsrc=%b stall=%b expected pcsrc=1 stall=0", pcsrc_o[0], stall_o[0]);
    end
    set_in(0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 2'b10, 0, 2'b00, 5'd0);
    checks++;
    if (pcsrc_o[0] !== 1'b0) begin failures++; $display("FAIL branch_zero0: got %b expected 0", pcsrc_o[0]); end
    set_in(0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 2'b10, 0, 2'b00, 5'd0);
    checks++;
    if (pcsrc_o[0] !== 1'b0) begin failures++; $display("FAIL branch_invalid: got %b expected 0", pcsrc_o[0]); end
    step();
  endtask

  task automatic test_misaligned();
    set_in(0, 1, 0, 0, 0, 1, 32'h13, 32'h12345678, 2'b10, 0, 2'b10, 5'd4);
    step();
    checks++;
    if ({mis[0], rdata[0], vo[0], ctrl_o[0]} !== {1'b1, 32'h0, 1'b1, 2'b10}) begin
      failures++;
      $display("FAIL mis_store: got mis=%b rd=%h vo=%b ctrl=%b expected mis=1 rd=0 vo=1 ctrl=10",
               mis[0], rdata[0], vo[0], ctrl_o[0]);
    end
    set_in(0, 1, 0, 0, 1, 0, 32'h10, 32'h0, 2'b10, 0, 2'b01, 5'd4);
    step();
    checks++;
    if ({mis[0], rdata[0]} !== {1'b0, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL mis_readback: got mis=%b rd=%h expected mis=0 rd=deadbeef", mis[0], rdata[0]);
    end
    set_in(0, 1, 0, 0, 1, 0, 32'h12, 32'h0, 2'b10, 0, 2'b01, 5'd4);
    step();
    checks++;
    if ({mis[0], rdata[0]} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL mis_load: got mis=%b rd=%h expected mis=1 rd=0", mis[0], rdata[0]);
    end
  endtask

  task automatic test_subword();
    set_in(0, 1, 0, 0, 0, 1, 32'h20, 32'h0, 2'b10, 0, 2'b01, 5'd1);
    step();
`ifdef MEM_STAGE_SUBWORD_EN
    set_in(0, 1, 0, 0, 0, 1, 32'h21, 32'h80, 2'b00, 0, 2'b01, 5'd1);
    step();
    checks++;
    if (mis[0] !== 1'b0) begin failures++; $display("FAIL sub_byte_store_mis: got %b expected 0", mis[0]); end
    set_in(0, 1, 0, 0, 1, 0, 32'h20, 32'h0, 2'b10, 0, 2'b01, 5'd1);
    step();
    checks++;
    if (rdata[0] !== 32'h00008000) begin failures++; $display("FAIL sub_word_load: got %h expected 00008000", rdata[0]); end
    set_in(0, 1, 0, 0, 1, 0, 32'h21, 32'h0, 2'b00, 0, 2'b01, 5'd1);
    step();
    checks++;
    if (rdata[0] !== 32'hFFFFFF80) begin failures++; $display("FAIL sub_byte_signed: got %h expected ffffff80", rdata[0]); end
    set_in(0, 1, 0, 0, 1, 0, 32'h21, 32'h0, 2'b00, 1, 2'b01, 5'd1);
    step();
    checks++;
    if (rdata[0] !== 32'h00000080) begin failures++; $display("FAIL sub_byte_unsigned: got %h expected 00000080", rdata[0]); end
    set_in(0, 1, 0, 0, 1, 0, 32'h20, 32'h0, 2'b01, 0, 2'b01, 5'd1);
    step();
    checks++;
    if (rdata[0] !== 32'hFFFF8000) begin failures++; $display("FAIL sub_half_signed: got %h expected ffff8000", rdata[0]); end
    set_in(0, 1, 0, 0, 1, 0, 32'h21, 32'h0, 2'b01, 0, 2'b01, 5'd1);
    step();
    checks++;
    if ({mis[0], rdata[0]} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL sub_half_mis: got mis=%b rd=%h expected mis=1 rd=0", mis[0], rdata[0]);
    end
`else
    set_in(0, 1, 0, 0, 0, 1, 32'h21, 32'h80, 2'b00, 0, 2'b01, 5'd1);
    step();
    checks++;
    if (mis[0] !== 1'b1) begin failures++; $display("FAIL word_byte_store_mis: got %b expected 1", mis[0]); end
    set_in(0, 1, 0, 0, 1, 0, 32'h20, 32'h0, 2'b10, 0, 2'b01, 5'd1);
    step();
    checks++;
    if (rdata[0] !== 32'h0) begin failures++; $display("FAIL word_unchanged: got %h expected 00000000", rdata[0]); end
    set_in(0, 1, 0, 0, 0, 1, 32'h24, 32'hAABBCCDD, 2'b00, 0, 2'b01, 5'd1);
    step();
    set_in(0, 1, 0, 0, 1, 0, 32'h24, 32'h0, 2'b00, 1, 2'b01, 5'd1);
    step();
    checks++;
    if ({mis[0], rdata[0]} !== {1'b0, 32'hAABBCCDD}) begin
      failures++;
      $display("FAIL word_size_ignored: got mis=%b rd=%h expected mis=0 rd=aabbccdd", mis[0], rdata[0]);
    end
`endif
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 2'b00, 5'd0);
    step();
  endtask

  task automatic test_back_to_back();
    logic        op_wr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] op_a   [4] = '{32'h40, 32'h44, 32'h40, 32'h44};
    logic [31:0] op_d   [4] = '{32'hCAFEF00D, 32'h0BADCAFE, 32'h0, 32'h0};
    logic [31:0] op_exp [4] = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0BADCAFE};
    int load_stalls = 0;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      set_in(1, 1, 0, 0, ~op_wr[i], op_wr[i], op_a[i], op_d[i], 2'b10, 0, 2'b01, 5'd9);
      while (stall_o[1] && n < 20) begin
        step();
        n++;
        checks++;
        if (vo[1] !== 1'b0) begin failures++; $display("FAIL wait_bubble op%0d cyc%0d: got vo=%b expected 0", i, n, vo[1]); end
      end
      step();
      checks++;
      if (n !== 3) begin failures++; $display("FAIL wait_stall_count op%0d: got %0d expected 3", i, n); end
      checks++;
      if ({vo[1], rdata[1]} !== {1'b1, op_exp[i]}) begin
        failures++;
        $display("FAIL wait_result op%0d: got vo=%b rd=%h expected vo=1 rd=%h", i, vo[1], rdata[1], op_exp[i]);
      end
      if (i >= 2) load_stalls += n;
    end
    checks++;
    if (load_stalls !== 6) begin failures++; $display("FAIL wait_b2b_total: got %0d expected 6", load_stalls); end
    set_in(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 2'b00, 5'd0);
    step();
  endtask

  task automatic test_reset_abort();
    int n = 0;
    set_in(2, 1, 0, 0, 0, 1, 32'h80, 32'h55AA55AA, 2'b10, 0, 2'b01, 5'd2);
    while (stall_o[2] && n < 20) begin step(); n++; end
    step();
    checks++;
    if (n !== 4) begin failures++; $display("FAIL abort_preload_stalls: got %0d expected 4", n); end
    set_in(2, 1, 0, 0, 0, 1, 32'h80, 32'hFFFFFFFF, 2'b10, 0, 2'b11, 5'd6);
    step();
    checks++;
    if (stall_o[2] !== 1'b1) begin failures++; $display("FAIL abort_second_stall: got %b expected 1", stall_o[2]); end
    reset = 1'b1;
    step();
    checks++;
    if ({vo[2], ctrl_o[2], rdata[2], alu_o[2], wreg_o[2], mis[2]} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got vo=%b ctrl=%b rd=%h alu=%h reg=%h mis=%b expected all 0",
               vo[2], ctrl_o[2], rdata[2], alu_o[2], wreg_o[2], mis[2]);
    end
    reset = 1'b0;
    set_in(2, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 2'b00, 5'd0);
    checks++;
    if (stall_o[2] !== 1'b0) begin failures++; $display("FAIL abort_stall_after: got %b expected 0", stall_o[2]); end
    step();
    n = 0;
    set_in(2, 1, 0, 0, 1, 0, 32'h80, 32'h0, 2'b10, 0, 2'b01, 5'd2);
    while (stall_o[2] && n < 20) begin step(); n++; end
    step();
    checks++;
    if ({n == 4, rdata[2]} !== {1'b1, 32'h55AA55AA}) begin
      failures++;
      $display("FAIL abort_word_unchanged: got stalls=%0d rd=%h expected stalls=4 rd=55aa55aa", n, rdata[2]);
    end
    set_in(2, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 2'b00, 5'd0);
    step();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      vi[d] = 0; br[d] = 0; zr[d] = 0; rd[d] = 0; wr[d] = 0; uns[d] = 0;
      ctrl_in[d] = 0; sz[d] = 0; addr[d] = 0; wd[d] = 0; wreg[d] = 0;
    end
    reset = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_branch();
    test_misaligned();
    test_subword();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_waitstate.md
# mem_stage_waitstate

Parametrised memory (MEM) stage for the 5-stage pipeline: branch resolution, on-chip data RAM access with a configurable number of wait states, and the MEM/WB pipeline register. It sits between the EX/MEM latch and write-back. It raises `stall` to freeze upstream stages while a multi-cycle access completes, and inserts a bubble into WB for each stall cycle.

## Interface
Parameters:
- `DATA_W`, 32: data and address width.
- `DEPTH`, 256: RAM depth in words, power of two, minimum 4.
- `WAIT_STATES`, 0: extra cycles per load or store, 0..15.
- `REG_W`, 5: destination register index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `valid_in`  in  1  the EX/MEM latch holds a real instruction.
- `wb_ctrl_in`  in  2  write-back control, passed through.
- `branch`, `mem_read`, `mem_write`  in  1 each  MEM control bits.
- `zero`  in  1  ALU zero flag.
- `alu_result`  in  DATA_W  byte address / ALU result.
- `write_data`  in  DATA_W  store data.
- `write_reg`  in  REG_W  destination register.
- `size`  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word).
- `unsigned_ld`  in  1  zero-extend sub-word loads.
- `pcsrc`  out  1  combinational: `valid_in & branch & zero`.
- `stall`  out  1  combinational; upstream must hold all inputs stable while high.
- `mem_wb_ctrl`  out  2  registered.
- `read_data`  out  DATA_W  registered.
- `mem_alu_result`  out  DATA_W  registered.
- `mem_write_reg`  out  REG_W  registered.
- `valid_out`  out  1  registered.
- `misaligned`  out  1  registered; the access was suppressed.

## Operation
- Memory instruction: `valid_in & (mem_read | mem_write)`. Simultaneous read and write is treated as a write; `read_data` is 0.
- Word index: `alu_result[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states are IDLE and WAIT, with a 4-bit counter `cnt`.
  - IDLE, memory instruction, `WAIT_STATES>0`: `stall=1`, `cnt<=WAIT_STATES-1`, go to WAIT. The output latch loads a bubble.
  - WAIT, `cnt!=0`: `stall=1`, `cnt<=cnt-1`, bubble.
  - WAIT, `cnt==0`: `stall=0`. The access commits, the latch loads the instruction, and the FSM returns to IDLE.
  - IDLE, any other case: `stall=0`. The access (if any) commits and the latch loads the instruction.
- Bubble: `valid_out=0`, `mem_wb_ctrl=0`; other registered outputs hold their previous values.
- Non-memory instructions and `valid_in=0` never stall. `valid_in=0` loads a bubble.
- Misalignment: a word access with `addr[1:0]!=0`, or a half access with `addr[0]=1`, is misaligned.
  - No RAM write occurs, `read_data=0`, and `misaligned=1`.
  - The instruction still completes, with `wb_ctrl` passed through unchanged.
- RAM contents are not reset.

## Timing
- Reset: the FSM goes to IDLE with `cnt=0`, and every registered output is 0. Reset during WAIT aborts the access: no write, no output.
- `WAIT_STATES=0`: load/store latency is 1 cycle. A load issued in cycle N has its data on `read_data` after edge N. A store commits at edge N.
- `WAIT_STATES=W`: `stall` is high for exactly W consecutive cycles, and the instruction occupies W+1 cycles.
  - The write commits, and read data is latched, at the edge ending cycle W+1.
  - Back-to-back memory instructions each pay W stall cycles, with no idle cycle between them.
- `pcsrc` is valid in the same cycle the branch is presented. It is unaffected by `stall`: the same instruction is held, so the value is the same.
- A store followed by a load to the same word returns the new data, because the write commits before the next access.

## Configuration
- `MEM_STAGE_SUBWORD_EN` defined:
  - Byte and half stores write only their lanes (little-endian).
  - Loads select the lane and sign-extend, or zero-extend when `unsigned_ld=1`.
- Not defined:
  - `size` and `unsigned_ld` are ignored, and every access is a full word.
  - `misaligned` is set only on `addr[1:0]!=0`.

## Test plan
- Reset, then `WAIT_STATES=0`: store 0xDEADBEEF to address 0x10, then load 0x10. After the load edge, `read_data=0xDEADBEEF`, `valid_out=1`, and `stall` is never high.
- `WAIT_STATES=3`, a load: `stall` is high for exactly 3 cycles, `valid_out=0` for 3 cycles, and data appears on the 4th edge. Two back-to-back loads give 6 stall cycles total.
- `branch=1`, `zero=1`, `valid_in=1`: `pcsrc=1` in the same cycle. With `zero=0` or `valid_in=0`: `pcsrc=0`.
- Word store to 0x13: `misaligned=1`, memory is unchanged (a read-back of 0x10 returns the old value), `read_data=0`.
- With `MEM_STAGE_SUBWORD_EN`: store byte 0x80 to 0x21 over a word of 0. Then:
  - a word load gives 0x00008000;
  - a signed byte load gives 0xFFFFFF80;
  - a `unsigned_ld` byte load gives 0x00000080.
- `WAIT_STATES=4`, store in flight, `reset` asserted in the 2nd stall cycle: all outputs 0, `stall=0` on the next cycle, and the target word is unchanged.
